// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the generator and pixel consumers
package vga_timing_pkg;

    // Width of the horizontal/vertical position counters and of DrawX/DrawY
    localparam int CNT_W = 10;

    // Horizontal timing in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Completed-frame counter width
    localparam int VGA_FCNT_W = 8;

    // Derived totals and sync windows (sync is low for START <= pos < END)
    localparam int VGA_H_TOT        = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOT        = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // True when pos lies in the half-open window [lo, hi)
    function automatic logic inWindow(input logic [CNT_W-1:0] pos,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters with registered sync, blank,
// position and frame-event outputs, all aligned one cycle behind the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int FCNT_W   = VGA_FCNT_W
) (
    input  logic              vga_clk,
    input  logic              reset,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic [CNT_W-1:0]  DrawX,
    output logic [CNT_W-1:0]  DrawY,
    output logic              line_start,
    output logic              frame_start,
    output logic              vblank_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]  hc_q, hc_d;
    logic [CNT_W-1:0]  vc_q, vc_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic [CNT_W-1:0]  drawX_q;
    logic [CNT_W-1:0]  drawY_q;
    logic              lineStart_q, lineStart_d;
    logic              frameStart_q, frameStart_d;
    logic              vblankStart_q, vblankStart_d;
    logic [FCNT_W-1:0] frameCnt_q, frameCnt_d;

    // Raster advance: hc wraps every line, vc steps (and wraps) only on that same cycle
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    // Decode of the current counter position; the frame count bumps only when the
    // outputs are about to go from the last raster position to the origin, so the
    // first frame after reset reports zero
    always_comb begin
        blank_d       = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        hs_d          = !inWindow(hc_q, HS_START, HS_END);
        vs_d          = !inWindow(vc_q, VS_START, VS_END);
        lineStart_d   = (hc_q == '0);
        frameStart_d  = lineStart_d && (vc_q == '0);
        vblankStart_d = lineStart_d && (vc_q == V_ACT_C);
        frameCnt_d    = frameCnt_q;
        if (frameStart_d && (drawX_q == H_LAST) && (drawY_q == V_LAST)) begin
            frameCnt_d = frameCnt_q + 1'b1;
        end
    end

    // Position counters
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Output registers, one cycle behind the counters and mutually aligned
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            drawX_q       <= '0;
            drawY_q       <= '0;
            lineStart_q   <= 1'b0;
            frameStart_q  <= 1'b0;
            vblankStart_q <= 1'b0;
            frameCnt_q    <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            drawX_q       <= hc_q;
            drawY_q       <= vc_q;
            lineStart_q   <= lineStart_d;
            frameStart_q  <= frameStart_d;
            vblankStart_q <= vblankStart_d;
            frameCnt_q    <= frameCnt_d;
        end
    end

    assign hs           = hs_q;
    assign vs           = vs_q;
    assign blank        = blank_q;
    assign DrawX        = drawX_q;
    assign DrawY        = drawY_q;
    assign line_start   = lineStart_q;
    assign frame_start  = frameStart_q;
    assign vblank_start = vblankStart_q;
    assign frame_cnt    = frameCnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a full-size 640x480 generator for line timing and a
// shrunken-timing instance cycle by cycle against a position-based scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // Shrunken raster for the scoreboarded instance: 10 clocks per line, 8 lines per frame
    localparam int SH_ACT  = 4;
    localparam int SH_FP   = 2;
    localparam int SH_SYNC = 2;
    localparam int SH_BP   = 2;
    localparam int SV_ACT  = 3;
    localparam int SV_FP   = 1;
    localparam int SV_SYNC = 2;
    localparam int SV_BP   = 2;
    localparam int SH_TOT  = 10;
    localparam int SV_TOT  = 8;
    localparam int SFRAME  = 80;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } vgaOut_t;

    localparam vgaOut_t RST_OUT    = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    localparam vgaOut_t FULL_FIRST = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0};

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    logic       fHs, fVs, fBlank, fLs, fFs, fVbs;
    logic [9:0] fX, fY;
    logic [7:0] fFc;
    logic       sHs, sVs, sBlank, sLs, sFs, sVbs;
    logic [9:0] sX, sY;
    logic [7:0] sFc;

    vgaOut_t fullOut, smallOut;
    logic [11:0] rgb;

    vgaOut_t sbQ[$];
    longint  sbCyc;
    bit      sbActive;
    int      testsRun;
    int      testsFailed;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dutFull (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .hs           (fHs),
        .vs           (fVs),
        .blank        (fBlank),
        .DrawX        (fX),
        .DrawY        (fY),
        .line_start   (fLs),
        .frame_start  (fFs),
        .vblank_start (fVbs),
        .frame_cnt    (fFc)
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
        .V_ACTIVE (SV_ACT), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
        .FCNT_W   (8)
    ) dutSmall (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .hs           (sHs),
        .vs           (sVs),
        .blank        (sBlank),
        .DrawX        (sX),
        .DrawY        (sY),
        .line_start   (sLs),
        .frame_start  (sFs),
        .vblank_start (sVbs),
        .frame_cnt    (sFc)
    );

    assign fullOut  = {fHs, fVs, fBlank, fX, fY, fLs, fFs, fVbs, fFc};
    assign smallOut = {sHs, sVs, sBlank, sX, sY, sLs, sFs, sVbs, sFc};

    // Simple pixel consumer on the full-size instance: paints only visible pixels
    assign rgb = fBlank ? {4'hF, fX[3:0], fY[3:0]} : 12'h000;

    function automatic string fmt(vgaOut_t o);
        return $sformatf("hs=%b vs=%b blank=%b x=%0d y=%0d ls=%b fs=%b vbs=%b fc=%0d",
                         o.hs, o.vs, o.blank, o.x, o.y, o.ls, o.fs, o.vbs, o.fc);
    endfunction

    // Expected outputs of the shrunken instance k edges after reset release
    function automatic vgaOut_t expectAt(longint k);
        vgaOut_t e;
        longint  pos;
        int      x, y;
        pos     = k % SFRAME;
        x       = int'(pos % SH_TOT);
        y       = int'(pos / SH_TOT);
        e.hs    = !((x >= SH_ACT + SH_FP) && (x < SH_ACT + SH_FP + SH_SYNC));
        e.vs    = !((y >= SV_ACT + SV_FP) && (y < SV_ACT + SV_FP + SV_SYNC));
        e.blank = (x < SH_ACT) && (y < SV_ACT);
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.ls    = (x == 0);
        e.fs    = (pos == 0);
        e.vbs   = (x == 0) && (y == SV_ACT);
        e.fc    = 8'((k / SFRAME) % 256);
        return e;
    endfunction

    // Advance one clock, queueing the scoreboard expectation at the active edge
    task automatic tick();
        @(posedge vga_clk);
        if (sbActive) begin
            sbQ.push_back(expectAt(sbCyc));
            sbCyc++;
        end
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        vgaOut_t exp;
        reset    = 1'b1;
        sbActive = 1'b0;
        sbQ.delete();
        repeat (3) @(negedge vga_clk);
        testsRun++;
        if (fullOut !== RST_OUT) begin
            testsFailed++;
            $display("[TB] FAIL reset_full got %s exp %s", fmt(fullOut), fmt(RST_OUT));
        end
        testsRun++;
        if (smallOut !== RST_OUT) begin
            testsFailed++;
            $display("[TB] FAIL reset_small got %s exp %s", fmt(smallOut), fmt(RST_OUT));
        end
        reset    = 1'b0;
        sbCyc    = 0;
        sbActive = 1'b1;
        tick();
        testsRun++;
        if (fullOut !== FULL_FIRST) begin
            testsFailed++;
            $display("[TB] FAIL release_full got %s exp %s", fmt(fullOut), fmt(FULL_FIRST));
        end
        if (sbQ.size() != 0) begin
            exp = sbQ.pop_front();
            testsRun++;
            if (smallOut !== exp) begin
                testsFailed++;
                $display("[TB] FAIL release_small got %s exp %s", fmt(smallOut), fmt(exp));
            end
        end
    endtask

    task automatic test_line_timing();
        vgaOut_t exp;
        int blankCnt = 0;
        int hsCnt    = 0;
        int hsFirst  = -1;
        int lsCnt    = 0;
        for (int i = 0; i < 800; i++) begin
            if (fBlank === 1'b1) blankCnt++;
            if (fHs === 1'b0) begin
                if (hsFirst < 0) hsFirst = int'(fX);
                hsCnt++;
            end
            if (fLs === 1'b1) lsCnt++;
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_line got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
        end
        testsRun++;
        if (blankCnt != 640) begin
            testsFailed++;
            $display("[TB] FAIL line_blank_count got %0d exp 640", blankCnt);
        end
        testsRun++;
        if (hsCnt != 96) begin
            testsFailed++;
            $display("[TB] FAIL line_hs_count got %0d exp 96", hsCnt);
        end
        testsRun++;
        if (hsFirst != 656) begin
            testsFailed++;
            $display("[TB] FAIL line_hs_start got %0d exp 656", hsFirst);
        end
        testsRun++;
        if (lsCnt != 1) begin
            testsFailed++;
            $display("[TB] FAIL line_start_count got %0d exp 1", lsCnt);
        end
        testsRun++;
        if (fLs !== 1'b1 || fX !== 10'd0 || fY !== 10'd1) begin
            testsFailed++;
            $display("[TB] FAIL line_start_recur got ls=%b x=%0d y=%0d exp ls=1 x=0 y=1", fLs, fX, fY);
        end
    endtask

    task automatic test_frame_timing();
        vgaOut_t exp;
        bit found    = 1'b0;
        int vsCnt    = 0;
        int vsFirstX = -1;
        int vsFirstY = -1;
        int vbsCnt   = 0;
        int vbsX     = -1;
        int vbsY     = -1;
        int blankBad = 0;
        for (int i = 0; i < 2 * SFRAME && !found; i++) begin
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_frame_wait got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
            if (sFs === 1'b1) found = 1'b1;
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL frame_start_timeout got none exp frame_start within %0d cycles", 2 * SFRAME);
        end
        for (int i = 0; i < SFRAME; i++) begin
            if (sVs === 1'b0) begin
                if (vsFirstX < 0) begin
                    vsFirstX = int'(sX);
                    vsFirstY = int'(sY);
                end
                vsCnt++;
            end
            if (sVbs === 1'b1) begin
                vbsCnt++;
                vbsX = int'(sX);
                vbsY = int'(sY);
            end
            if (int'(sY) >= SV_ACT && sBlank !== 1'b0) blankBad++;
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_frame got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
        end
        testsRun++;
        if (vsCnt != SV_SYNC * SH_TOT) begin
            testsFailed++;
            $display("[TB] FAIL frame_vs_count got %0d exp %0d", vsCnt, SV_SYNC * SH_TOT);
        end
        testsRun++;
        if (vsFirstX != 0 || vsFirstY != SV_ACT + SV_FP) begin
            testsFailed++;
            $display("[TB] FAIL frame_vs_start got (%0d,%0d) exp (0,%0d)", vsFirstX, vsFirstY, SV_ACT + SV_FP);
        end
        testsRun++;
        if (vbsCnt != 1 || vbsX != 0 || vbsY != SV_ACT) begin
            testsFailed++;
            $display("[TB] FAIL frame_vblank_start got cnt=%0d at (%0d,%0d) exp cnt=1 at (0,%0d)", vbsCnt, vbsX, vbsY, SV_ACT);
        end
        testsRun++;
        if (blankBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL frame_blank_in_vblank got %0d visible cycles exp 0", blankBad);
        end
        testsRun++;
        if (sFs !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL frame_period got fs=%b exp fs=1 after %0d cycles", sFs, SFRAME);
        end
    endtask

    task automatic test_consumer();
        vgaOut_t exp;
        bit visible;
        for (int i = 0; i < 2000; i++) begin
            visible = (fX < 10'd640) && (fY < 10'd480);
            testsRun++;
            if ((rgb != 12'h000) !== visible) begin
                testsFailed++;
                $display("[TB] FAIL consumer_rgb got rgb=%h at (%0d,%0d) exp visible=%b", rgb, fX, fY, visible);
            end
            testsRun++;
            if (fX > 10'd799 || fY > 10'd524) begin
                testsFailed++;
                $display("[TB] FAIL consumer_range got (%0d,%0d) exp <= (799,524)", fX, fY);
            end
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_consumer got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        vgaOut_t exp;
        bit found = 1'b0;
        for (int i = 0; i < 2 * SFRAME && !found; i++) begin
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_mid_wait got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
            if (sX === 10'd5 && sY === 10'd2) found = 1'b1;
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_timeout got none exp position (5,2)");
        end
        reset    = 1'b1;
        sbActive = 1'b0;
        #1;
        testsRun++;
        if (smallOut !== RST_OUT) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_async_small got %s exp %s", fmt(smallOut), fmt(RST_OUT));
        end
        testsRun++;
        if (fullOut !== RST_OUT) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_async_full got %s exp %s", fmt(fullOut), fmt(RST_OUT));
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            testsRun++;
            if (smallOut !== RST_OUT || fullOut !== RST_OUT) begin
                testsFailed++;
                $display("[TB] FAIL mid_reset_hold got small %s full %s exp %s", fmt(smallOut), fmt(fullOut), fmt(RST_OUT));
            end
        end
        reset    = 1'b0;
        sbQ.delete();
        sbCyc    = 0;
        sbActive = 1'b1;
        tick();
        testsRun++;
        if (fullOut !== FULL_FIRST) begin
            testsFailed++;
            $display("[TB] FAIL mid_release_full got %s exp %s", fmt(fullOut), fmt(FULL_FIRST));
        end
        if (sbQ.size() != 0) begin
            exp = sbQ.pop_front();
            testsRun++;
            if (smallOut !== exp) begin
                testsFailed++;
                $display("[TB] FAIL mid_release_small got %s exp %s", fmt(smallOut), fmt(exp));
            end
        end
        for (int i = 0; i < 2 * SFRAME; i++) begin
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_mid_restart got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_counter_wrap();
        vgaOut_t exp;
        int frames = 0;
        reset    = 1'b1;
        sbActive = 1'b0;
        sbQ.delete();
        repeat (2) @(negedge vga_clk);
        reset    = 1'b0;
        sbCyc    = 0;
        sbActive = 1'b1;
        for (int i = 0; i < 257 * SFRAME + 20 && frames < 257; i++) begin
            tick();
            if (sbQ.size() != 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if (smallOut !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_wrap got %s exp %s", fmt(smallOut), fmt(exp));
                end
            end
            if (sFs === 1'b1) begin
                testsRun++;
                if (sFc !== 8'(frames % 256)) begin
                    testsFailed++;
                    $display("[TB] FAIL wrap_frame_cnt got %0d exp %0d at frame_start %0d", sFc, frames % 256, frames + 1);
                end
                frames++;
            end
        end
        testsRun++;
        if (frames != 257) begin
            testsFailed++;
            $display("[TB] FAIL wrap_timeout got %0d frame_starts exp 257", frames);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        sbCyc       = 0;
        sbActive    = 1'b0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_consumer();
        test_mid_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
